vrecip_issue_ctrl: RTL and testbench

- Vector-side initiator for the fp16 scalar reciprocal unit.
- Accepts one vector of LANES packed fp16 operands and issues them one at a time on the unit's divisor/divisor_valid interface.
- Collects each result on complete and returns the assembled result vector to the vector pipeline through a valid/ready handshake.
- Sits between the vector register read stage and the reciprocal unit.

---
 rtl/vrecip_pkg.sv | 27 ++
 rtl/vrecip_issue_ctrl_if.sv | 29 ++
 rtl/fp16_special_classify.sv | 27 ++
 rtl/vrecip_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_vrecip_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vrecip_pkg.sv
// Shared types, fp16 constants and field helpers for the vector reciprocal issue controller.
package vrecip_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } vrecip_state_e;

   localparam logic [4:0]  FP16_EXP_MAX = 5'd31;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [14:0] FP16_INF     = 15'h7C00;

   function automatic logic fp16_sign(input logic [15:0] x);
      return x[15];
   endfunction

   function automatic logic [4:0] fp16_exp(input logic [15:0] x);
      return x[14:10];
   endfunction

   function automatic logic [9:0] fp16_mant(input logic [15:0] x);
      return x[9:0];
   endfunction

endpackage

// File: rtl/vrecip_issue_ctrl_if.sv
// Bundle of the vector-side and reciprocal-unit-side signals of vrecip_issue_ctrl.
interface vrecip_issue_ctrl_if #(
   parameter int LANES = 8
);
   // vec_in and vec_out are valid/ready: a transfer happens on a rising clk edge where
   // both are high; the source holds data and valid stable until that edge.
   // divisor_valid and complete are one-cycle strobes with no back-pressure.
   logic [16*LANES-1:0] vec_in;
   logic                vec_in_valid;
   logic                vec_in_ready;
   logic [15:0]         divisor;
   logic                divisor_valid;
   logic [15:0]         result;
   logic                complete;
   logic [16*LANES-1:0] vec_out;
   logic                vec_out_valid;
   logic                vec_out_ready;

   modport master (
      input  vec_in, vec_in_valid, result, complete, vec_out_ready,
      output vec_in_ready, divisor, divisor_valid, vec_out, vec_out_valid
   );

   modport slave (
      output vec_in, vec_in_valid, result, complete, vec_out_ready,
      input  vec_in_ready, divisor, divisor_valid, vec_out, vec_out_valid
   );

endinterface

// File: rtl/fp16_special_classify.sv
// Classifies one fp16 operand and produces the reciprocal of the special classes
// (zero/subnormal flushed to zero, infinity, NaN) without using the reciprocal unit.
module fp16_special_classify
   import vrecip_pkg::*;
(
   input  logic [15:0] op,
   output logic        is_zero_or_sub,
   output logic        is_inf,
   output logic        is_nan,
   output logic [15:0] bypass_val
);

   always_comb begin
      is_zero_or_sub = (fp16_exp(op) == 5'd0);
      is_inf         = (fp16_exp(op) == FP16_EXP_MAX) && (fp16_mant(op) == 10'd0);
      is_nan         = (fp16_exp(op) == FP16_EXP_MAX) && (fp16_mant(op) != 10'd0);
      bypass_val     = 16'h0000;
      if (is_zero_or_sub) begin
         bypass_val = {fp16_sign(op), FP16_INF};
      end else if (is_inf) begin
         bypass_val = {fp16_sign(op), 15'h0000};
      end else if (is_nan) begin
         bypass_val = FP16_QNAN;
      end
   end

endmodule

// File: rtl/vrecip_issue_ctrl.sv
// Serialises a vector of fp16 operands onto the scalar reciprocal unit and reassembles
// the results. Define VRECIP_SPECIAL_BYPASS_EN to resolve zero/inf/NaN lanes locally.
module vrecip_issue_ctrl
   import vrecip_pkg::*;
#(
   parameter int LANES = 8,
   parameter int IDX_W = $clog2(LANES)
)(
   input  logic                clk,
   input  logic                rst,
   vrecip_issue_ctrl_if.master bus,
   output logic                busy,
   output vrecip_state_e       dbg_state
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   vrecip_state_e          state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [LANES-1:0][15:0] operand_q, operand_d;
   logic [LANES-1:0][15:0] res_buf_q, res_buf_d;
   logic [15:0]            divisor_q, divisor_d;
   logic                   divisor_valid_q, divisor_valid_d;
   logic                   vec_out_valid_q, vec_out_valid_d;
   logic [15:0]            cur_op;
   logic [15:0]            bypass_val;
   logic                   bypass;
   logic                   last_lane;
   logic                   in_ready;

   assign cur_op    = operand_q[idx_q];
   assign last_lane = (idx_q == LAST_IDX);
   assign in_ready  = (state_q == ST_IDLE);

`ifdef VRECIP_SPECIAL_BYPASS_EN
   logic cls_zero, cls_inf, cls_nan;

   fp16_special_classify u_classify (
      .op             (cur_op),
      .is_zero_or_sub (cls_zero),
      .is_inf         (cls_inf),
      .is_nan         (cls_nan),
      .bypass_val     (bypass_val)
   );

   assign bypass = cls_zero | cls_inf | cls_nan;
`else
   assign bypass     = 1'b0;
   assign bypass_val = 16'h0000;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         idx_q           <= '0;
         operand_q       <= '0;
         res_buf_q       <= '0;
         divisor_q       <= 16'h0000;
         divisor_valid_q <= 1'b0;
         vec_out_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         operand_q       <= operand_d;
         res_buf_q       <= res_buf_d;
         divisor_q       <= divisor_d;
         divisor_valid_q <= divisor_valid_d;
         vec_out_valid_q <= vec_out_valid_d;
      end
   end

   // A lane retires either through a bypass in ISSUE or a complete in WAIT; complete
   // seen in any other state belongs to nothing we issued and is dropped.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      operand_d = operand_q;
      res_buf_d = res_buf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.vec_in_valid && in_ready) begin
               operand_d = bus.vec_in;
               idx_d     = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bypass) begin
               res_buf_d[idx_q] = bypass_val;
               if (last_lane) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.complete) begin
               res_buf_d[idx_q] = bus.result;
               if (last_lane) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            if (vec_out_valid_q && bus.vec_out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      divisor_d       = divisor_q;
      divisor_valid_d = 1'b0;
      vec_out_valid_d = 1'b0;
      if ((state_q == ST_ISSUE) && !bypass) begin
         divisor_d       = cur_op;
         divisor_valid_d = 1'b1;
      end
      if (state_q == ST_DONE) begin
         vec_out_valid_d = !(vec_out_valid_q && bus.vec_out_ready);
      end
   end

   assign bus.vec_in_ready  = in_ready;
   assign bus.divisor       = divisor_q;
   assign bus.divisor_valid = divisor_valid_q;
   assign bus.vec_out       = res_buf_q;
   assign bus.vec_out_valid = vec_out_valid_q;
   assign busy              = (state_q != ST_IDLE);
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_vrecip_issue_ctrl.sv
// Bench for vrecip_issue_ctrl: reciprocal-unit model with fixed latency, per-cycle
// comparison against expectations derived from lane values; honours VRECIP_SPECIAL_BYPASS_EN.
module tb_vrecip_issue_ctrl;
   import vrecip_pkg::*;

   localparam int LANES = 4;
   localparam int L_RCP = 5;
   localparam int W     = 16 * LANES;
`ifdef VRECIP_SPECIAL_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          busy;
   vrecip_state_e dbg_state;

   vrecip_issue_ctrl_if #(.LANES(LANES)) bus ();

   vrecip_issue_ctrl #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int           errors = 0;
   int           checks = 0;
   int           edge_n = 0;
   int           cnt = 0;
   logic [15:0]  pend = '0;
   logic [15:0]  exp_q[$];
   logic [W-1:0] exp_out_q[$];
   int           accept_edge = 0;
   int           exp_lat = 0;
   bit           lat_armed = 1'b0;
   bit           prev_dv = 1'b0;
   bit           prev_vov = 1'b0;

   // Reciprocal unit stand-in: exact for powers of two, an arbitrary mapping otherwise.
   function automatic logic [15:0] rcp_model(input logic [15:0] x);
      if (x[9:0] == 10'd0 && x[14:10] >= 5'd1 && x[14:10] <= 5'd29)
         return {x[15], 5'd30 - x[14:10], 10'd0};
      return x ^ 16'h5A5A;
   endfunction

   function automatic bit is_special(input logic [15:0] x);
      return BYPASS_EN && ((x[14:10] == 5'd0) || (x[14:10] == 5'd31));
   endfunction

   function automatic logic [15:0] special_val(input logic [15:0] x);
      if (x[14:10] == 5'd0) return {x[15], 15'h7C00};
      if (x[9:0] == 10'd0) return {x[15], 15'h0000};
      return 16'h7E00;
   endfunction

   function automatic logic [15:0] rand_op(input bit allow_special);
      logic [15:0] x = 16'($urandom);
      if ($urandom_range(0, 2) == 0) x[9:0] = 10'd0;
      if (allow_special && $urandom_range(0, 3) == 0)
         x[14:10] = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'd31;
      else if (x[14:10] == 5'd0 || x[14:10] == 5'd31)
         x[14:10] = 5'd15;
      return x;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, expv);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired at edge %0d", name, edge_n);
   endtask

   // One cycle: advance to the falling edge and update the reciprocal-unit model.
   task automatic cyc();
      @(negedge clk);
      bus.complete = 1'b0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            bus.complete = 1'b1;
            bus.result   = pend;
         end
      end
      if (bus.divisor_valid && !rst) begin
         cnt  = L_RCP;
         pend = rcp_model(bus.divisor);
      end
   endtask

   task automatic send(input logic [W-1:0] v, input bit use_lit,
                       input logic [W-1:0] lit_out, input int lit_lat);
      logic [W-1:0] m_out = '0;
      int           m_lat = 1;
      for (int i = 0; i < LANES; i++) begin
         if (is_special(v[16*i +: 16])) begin
            m_out[16*i +: 16] = special_val(v[16*i +: 16]);
            m_lat += 1;
         end else begin
            m_out[16*i +: 16] = rcp_model(v[16*i +: 16]);
            m_lat += L_RCP + 2;
         end
      end
      if (use_lit) begin
         chk("model_pin_out", m_out, lit_out);
         chk("model_pin_lat", m_lat, lit_lat);
         m_out = lit_out;
         m_lat = lit_lat;
      end
      bus.vec_in       = v;
      bus.vec_in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         if (bus.vec_in_ready) begin
            for (int i = 0; i < LANES; i++)
               if (!is_special(v[16*i +: 16])) exp_q.push_back(v[16*i +: 16]);
            exp_out_q.push_back(m_out);
            accept_edge = edge_n + 1;
            exp_lat     = m_lat;
            lat_armed   = 1'b1;
            cyc();
            bus.vec_in_valid = 1'b0;
            return;
         end
         cyc();
      end
      bus.vec_in_valid = 1'b0;
      fail("accept_timeout");
   endtask

   task automatic drain(input bit rand_ready);
      for (int t = 0; t < 400; t++) begin
         bus.vec_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.vec_out_valid && bus.vec_out_ready) begin
            cyc();
            if (exp_out_q.size() > 0) void'(exp_out_q.pop_front());
            bus.vec_out_ready = 1'b0;
            chk("issues_left", exp_q.size(), 0);
            chk("idle_after_accept", bus.vec_in_ready, 1);
            return;
         end
         cyc();
      end
      bus.vec_out_ready = 1'b0;
      fail("drain_timeout");
   endtask

   // Per-cycle comparison, one time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         #1;
         if (rst) begin
            prev_dv  = 1'b0;
            prev_vov = 1'b0;
         end else begin
            if (bus.divisor_valid) begin
               chk("dv_pulse_width", prev_dv, 0);
               chk("issue_while_outstanding", cnt, 0);
               chk("busy_on_issue", busy, 1);
               if (exp_q.size() == 0) fail("unexpected_issue");
               else chk("divisor", bus.divisor, exp_q.pop_front());
            end
            if (bus.vec_out_valid) begin
               chk("in_ready_in_done", bus.vec_in_ready, 0);
               if (exp_out_q.size() == 0) fail("unexpected_vec_out_valid");
               else chk("vec_out", bus.vec_out, exp_out_q[0]);
               if (!prev_vov && lat_armed) begin
                  chk("latency", edge_n - accept_edge, exp_lat);
                  lat_armed = 1'b0;
               end
            end
            prev_dv  = bus.divisor_valid;
            prev_vov = bus.vec_out_valid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at edge %0d", edge_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] v;
      bus.vec_in        = '0;
      bus.vec_in_valid  = 1'b0;
      bus.vec_out_ready = 1'b0;
      bus.complete      = 1'b0;
      bus.result        = '0;
      repeat (3) cyc();
      chk("rst_divisor", bus.divisor, 16'h0000);
      chk("rst_dv", bus.divisor_valid, 0);
      chk("rst_vec_out", bus.vec_out, '0);
      chk("rst_vov", bus.vec_out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", bus.vec_in_ready, 1);
      rst = 1'b0;
      cyc();

      // Power-of-two lanes with hand-derived results and latency, then held output.
      send(64'h3800_3C00_4000_4400, 1'b1, 64'h4000_3C00_3800_3400, 29);
      for (int t = 0; t < 100 && !bus.vec_out_valid; t++) cyc();
      if (!bus.vec_out_valid) fail("first_valid_timeout");
      for (int i = 0; i < 10; i++) begin
         bus.vec_in       = {$urandom, $urandom};
         bus.vec_in_valid = 1'b1;
         cyc();
         chk("hold_in_ready", bus.vec_in_ready, 0);
         chk("hold_vov", bus.vec_out_valid, 1);
         chk("hold_vec_out", bus.vec_out, 64'h4000_3C00_3800_3400);
      end
      bus.vec_in_valid  = 1'b0;
      bus.vec_out_ready = 1'b1;
      cyc();
      if (exp_out_q.size() > 0) void'(exp_out_q.pop_front());
      bus.vec_out_ready = 1'b0;
      chk("ret_idle_ready", bus.vec_in_ready, 1);
      chk("ret_idle_busy", busy, 0);
      chk("ret_idle_vov", bus.vec_out_valid, 0);
      chk("hold_issues_left", exp_q.size(), 0);

      // Stray complete in IDLE leaves the result buffer alone.
      bus.complete = 1'b1;
      bus.result   = 16'hBEEF;
      cyc();
      chk("idle_cpl_vec_out", bus.vec_out, 64'h4000_3C00_3800_3400);
      chk("idle_cpl_ready", bus.vec_in_ready, 1);

      // Stray complete while the first lane sits in ISSUE.
      for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_op(1'b0);
      send(v, 1'b0, '0, 0);
      bus.complete = 1'b1;
      bus.result   = 16'hDEAD;
      drain(1'b1);

      // Reset while waiting on lane 2; the unit's late complete must be ignored.
      for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_op(1'b0);
      send(v, 1'b0, '0, 0);
      for (int t = 0; t < 100 && !(exp_q.size() == 1 && cnt > 0); t++) cyc();
      if (!(exp_q.size() == 1 && cnt > 0)) fail("wait_lane2_timeout");
      rst = 1'b1;
      cnt = 3;
      exp_q.delete();
      exp_out_q.delete();
      lat_armed = 1'b0;
      cyc();
      chk("mid_rst_divisor", bus.divisor, 16'h0000);
      chk("mid_rst_dv", bus.divisor_valid, 0);
      chk("mid_rst_vov", bus.vec_out_valid, 0);
      chk("mid_rst_vec_out", bus.vec_out, '0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;
      repeat (4) cyc();
      chk("stray_busy", busy, 0);
      chk("stray_in_ready", bus.vec_in_ready, 1);
      chk("stray_vec_out", bus.vec_out, '0);
      send(64'h3800_3C00_4000_4400, 1'b1, 64'h4000_3C00_3800_3400, 29);
      drain(1'b0);

      // Special-class lanes: bypassed when the feature is built in, issued otherwise.
      if (BYPASS_EN) send(64'h7E01_7C00_8000_0000, 1'b1, 64'h7E00_0000_FC00_7C00, 5);
      else send(64'h7E01_7C00_8000_0000, 1'b0, '0, 0);
      drain(1'b0);

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_op(1'b1);
         send(v, 1'b0, '0, 0);
         drain(1'b1);
      end

      repeat (3) cyc();
      chk("end_issue_queue", exp_q.size(), 0);
      chk("end_out_queue", exp_out_q.size(), 0);
      chk("end_busy", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
